// File: rtl/alu_issue_queue_if.sv
// ============================================================================
// Module      : alu_issue_queue_if
// Description : Command-in, ALU-drive and result-out bundle for alu_issue_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_issue_queue_if #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_opcode;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [OP_W-1:0]   alu_opcode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_issue;
    logic [DATA_W-1:0] alu_result;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [OP_W-1:0]   out_opcode;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_opcode, in_a, in_b, alu_result, out_ready,
        input  in_ready, alu_opcode, alu_a, alu_b, alu_issue,
               out_valid, out_result, out_opcode, count
    );

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, alu_result, out_ready,
        output in_ready, alu_opcode, alu_a, alu_b, alu_issue,
               out_valid, out_result, out_opcode, count
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue_queue.sv
// ============================================================================
// Module      : alu_issue_queue
// Description : Command FIFO and in-order issue stage in front of a fixed-latency ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_queue #(
    parameter int DATA_W  = 16,
    parameter int OP_W    = 4,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_queue_if.slave bus
);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int RES_DEPTH = ALU_LAT + 1;
    localparam int RPTR_W    = $clog2(RES_DEPTH);
    localparam int RCNT_W    = $clog2(RES_DEPTH + 1);
    localparam int OCC_W     = RCNT_W + 1;

    logic [OP_W-1:0]   cmd_op_q [DEPTH];
    logic [DATA_W-1:0] cmd_a_q  [DEPTH];
    logic [DATA_W-1:0] cmd_b_q  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    logic              alu_issue_q;
    logic [OP_W-1:0]   alu_opcode_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;

    logic [DATA_W-1:0] res_data_q [RES_DEPTH];
    logic [OP_W-1:0]   res_op_q   [RES_DEPTH];
    logic [RPTR_W-1:0] res_wr_q;
    logic [RPTR_W-1:0] res_rd_q;
    logic [RCNT_W-1:0] res_count_q;
    logic [RCNT_W-1:0] res_count_d;

    logic [ALU_LAT-1:0]           w_stage_vld;
    logic [ALU_LAT-1:0][OP_W-1:0] w_stage_op;
    logic [RCNT_W-1:0]            w_inflight;
    logic [OCC_W-1:0]             w_occupied;
    logic [OCC_W-1:0]             w_limit;
    logic                         w_in_ready;
    logic                         w_push;
    logic                         w_issue;
    logic                         w_capture;
    logic                         w_out_valid;
    logic                         w_out_pop;

    function automatic logic [RPTR_W-1:0] res_ptr_inc(input logic [RPTR_W-1:0] p);
        return (p == RPTR_W'(RES_DEPTH - 1)) ? '0 : p + RPTR_W'(1);
    endfunction

    assign w_in_ready  = !rst && (count_q < CNT_W'(DEPTH));
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_out_valid = (res_count_q != '0);
    assign w_out_pop   = w_out_valid && bus.out_ready;

    // Stage 0 of the in-flight pipe is the ALU input register itself.
    assign w_stage_vld[0] = alu_issue_q;
    assign w_stage_op[0]  = alu_opcode_q;
    assign w_capture      = w_stage_vld[ALU_LAT-1];

    generate
        if (ALU_LAT > 1) begin : g_pipe
            logic [ALU_LAT-1:1]           vld_q;
            logic [ALU_LAT-1:1][OP_W-1:0] op_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                    op_q  <= '0;
                end else begin
                    vld_q[1] <= alu_issue_q;
                    op_q[1]  <= alu_opcode_q;
                    for (int i = 2; i < ALU_LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        op_q[i]  <= op_q[i-1];
                    end
                end
            end

            assign w_stage_vld[ALU_LAT-1:1] = vld_q;
            assign w_stage_op[ALU_LAT-1:1]  = op_q;
        end : g_pipe
    endgenerate

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < ALU_LAT; i++) begin
            w_inflight = w_inflight + RCNT_W'(w_stage_vld[i]);
        end
    end

    // A result leaving this edge frees its slot for a command issued on the same edge,
    // which is what sustains one command per cycle with a two-entry buffer.
    assign w_occupied = OCC_W'(w_inflight) + OCC_W'(res_count_q);
    assign w_limit    = OCC_W'(RES_DEPTH) + OCC_W'(w_out_pop);
    assign w_issue    = (count_q != '0) && (w_occupied < w_limit);

    always_comb begin
        count_d = count_q;
        case ({w_push, w_issue})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        res_count_d = res_count_q;
        case ({w_capture, w_out_pop})
            2'b10:   res_count_d = res_count_q + RCNT_W'(1);
            2'b01:   res_count_d = res_count_q - RCNT_W'(1);
            default: res_count_d = res_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            alu_issue_q  <= 1'b0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            res_wr_q     <= '0;
            res_rd_q     <= '0;
            res_count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_issue) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q      <= count_d;
            alu_issue_q  <= w_issue;
            alu_opcode_q <= w_issue ? cmd_op_q[rd_ptr_q] : '0;
            alu_a_q      <= w_issue ? cmd_a_q[rd_ptr_q]  : '0;
            alu_b_q      <= w_issue ? cmd_b_q[rd_ptr_q]  : '0;
            if (w_capture) begin
                res_wr_q <= res_ptr_inc(res_wr_q);
            end
            if (w_out_pop) begin
                res_rd_q <= res_ptr_inc(res_rd_q);
            end
            res_count_q <= res_count_d;
        end
    end

    // Storage arrays carry no reset; occupancy counters alone decide what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            cmd_op_q[wr_ptr_q] <= bus.in_opcode;
            cmd_a_q[wr_ptr_q]  <= bus.in_a;
            cmd_b_q[wr_ptr_q]  <= bus.in_b;
        end
        if (w_capture) begin
            res_data_q[res_wr_q] <= bus.alu_result;
            res_op_q[res_wr_q]   <= w_stage_op[ALU_LAT-1];
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.count      = count_q;
    assign bus.alu_issue  = alu_issue_q;
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_result = w_out_valid ? res_data_q[res_rd_q] : '0;
    assign bus.out_opcode = w_out_valid ? res_op_q[res_rd_q]   : '0;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
// ============================================================================
// Module      : tb_alu_issue_queue
// Description : Directed self-checking bench for alu_issue_queue with an ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_queue;
    localparam int DATA_W  = 16;
    localparam int OP_W    = 4;
    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_issue_queue_if #(.DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH)) bus ();

    alu_issue_queue #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .DEPTH  (DEPTH),
        .ALU_LAT(ALU_LAT)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Single-cycle ALU: result is valid while its operands sit in the issue register.
    always_comb begin
        case (bus.alu_opcode)
            4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
            4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
            4'b0011: bus.alu_result = bus.alu_a ^ bus.alu_b;
            4'b0100: bus.alu_result = bus.alu_a - bus.alu_b;
            default: bus.alu_result = bus.alu_a;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [19:0] exp_q[$];
    logic        mon_en    = 1'b0;
    logic        hold_pend = 1'b0;
    logic [19:0] hold_val  = '0;
    logic [19:0] mon_e;
    logic        t4_done   = 1'b0;

    // Result monitor: in-order scoreboard plus stall-hold check.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (hold_pend) begin
                check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
                check_eq("hold_data", 32'({bus.out_opcode, bus.out_result}), 32'(hold_val));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("out_result", 32'(bus.out_result), 32'(mon_e[15:0]));
                    check_eq("out_opcode", 32'(bus.out_opcode), 32'(mon_e[19:16]));
                end
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_val  = {bus.out_opcode, bus.out_result};
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res);
        logic acc;
        acc = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_a      = a;
        bus.in_b      = b;
        for (int t = 0; t < 64 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) exp_q.push_back({op, res});
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) check_eq("push_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values();
        check_eq("rst_in_ready",   32'(bus.in_ready),   32'd1);
        check_eq("rst_count",      32'(bus.count),      32'd0);
        check_eq("rst_alu_issue",  32'(bus.alu_issue),  32'd0);
        check_eq("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
        check_eq("rst_alu_a",      32'(bus.alu_a),      32'd0);
        check_eq("rst_alu_b",      32'(bus.alu_b),      32'd0);
        check_eq("rst_out_valid",  32'(bus.out_valid),  32'd0);
        check_eq("rst_out_result", 32'(bus.out_result), 32'd0);
        check_eq("rst_out_opcode", 32'(bus.out_opcode), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        // Reset
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("in_ready_during_rst", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Single command latency: 3+4 with opcode 0010
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_opcode = 4'b0010;
        bus.in_a      = 16'd3;
        bus.in_b      = 16'd4;
        exp_q.push_back({4'b0010, 16'd7});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("t1_count", 32'(bus.count), 32'd1);
        check_eq("t1_issue_early", 32'(bus.alu_issue), 32'd0);
        @(negedge clk);
        check_eq("t1_issue", 32'(bus.alu_issue), 32'd1);
        check_eq("t1_alu_opcode", 32'(bus.alu_opcode), 32'h2);
        check_eq("t1_alu_a", 32'(bus.alu_a), 32'd3);
        check_eq("t1_alu_b", 32'(bus.alu_b), 32'd4);
        check_eq("t1_out_valid_early", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check_eq("t1_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("t1_out_result", 32'(bus.out_result), 32'd7);
        check_eq("t1_out_opcode", 32'(bus.out_opcode), 32'h2);
        @(negedge clk);
        check_eq("t1_out_valid_after", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;

        // Backpressure: six accepted with out_ready low
        bus.out_ready = 1'b0;
        push(4'b0010, 16'h0001, 16'h0001, 16'h0002);
        push(4'b0010, 16'h00FF, 16'h0001, 16'h0100);
        push(4'b0010, 16'hFFFF, 16'h0001, 16'h0000);
        push(4'b0100, 16'h0010, 16'h0001, 16'h000F);
        push(4'b0000, 16'hF0F0, 16'h0FF0, 16'h00F0);
        push(4'b0011, 16'hAAAA, 16'hFFFF, 16'h5555);
        @(negedge clk);
        check_eq("t2_count_full", 32'(bus.count), 32'd4);
        check_eq("t2_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("t2_head", 32'({bus.out_opcode, bus.out_result}), 32'h20002);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drain();

        // Back-to-back stream of ten
        for (int i = 0; i < 10; i++) begin
            check_eq("t3_in_ready", 32'(bus.in_ready), 32'd1);
            push(4'b0010, 16'(i) * 16'h1111, 16'h0101, 16'(i) * 16'h1111 + 16'h0101);
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("t3_throughput", 32'(exp_q.size()), 32'd0);
        check_eq("t3_out_valid_idle", 32'(bus.out_valid), 32'd0);

        // Random out_ready during 5-9 stream
        t4_done = 1'b0;
        fork
            begin
                while (!t4_done) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 8; i++) push(4'b0100, 16'd5, 16'd9, 16'hFFFC);
        t4_done = 1'b1;
        @(posedge clk); #1;
        drain();

        // Full FIFO: push refused on the edge that pops
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(4'b0011, 16'(i), 16'h00FF, 16'(i) ^ 16'h00FF);
        bus.in_valid  = 1'b1;
        bus.in_opcode = 4'b0001;
        bus.in_a      = 16'h1200;
        bus.in_b      = 16'h0034;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("t5_count_before", 32'(bus.count), 32'd4);
        check_eq("t5_in_ready_full", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check_eq("t5_count_after_pop", 32'(bus.count), 32'd3);
        check_eq("t5_in_ready_open", 32'(bus.in_ready), 32'd1);
        exp_q.push_back({4'b0001, 16'h1234});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq("t5_count_refill", 32'(bus.count), 32'd4);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        drain();

        // Reset with 3 queued, 1 in flight, 1 buffered
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(4'b0010, 16'(i), 16'h0010, 16'(i) + 16'h0010);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_opcode = 4'b0010;
        bus.in_a      = 16'h0020;
        bus.in_b      = 16'h0010;
        @(negedge clk);
        check_eq("t6_pre_count", 32'(bus.count), 32'd3);
        check_eq("t6_pre_out_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        rst          = 1'b1;
        mon_en       = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_eq("t6_in_ready_rst", 32'(bus.in_ready), 32'd0);
        check_eq("t6_mid_count", 32'(bus.count), 32'd3);
        check_eq("t6_mid_issue", 32'(bus.alu_issue), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        mon_en        = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("t6_no_stale_valid", 32'(bus.out_valid), 32'd0);
            check_eq("t6_no_stale_issue", 32'(bus.alu_issue), 32'd0);
        end
        @(posedge clk); #1;
        push(4'b0000, 16'h00FF, 16'h0F0F, 16'h000F);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
